uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter (`top`: FSM, PISO, parity and mux path) between `NUM_REQ` byte producers. It picks one pending requester, latches its byte, pulses `tx_start`, then tracks the transmitter's `tx_busy` through the whole frame before granting again. A watchdog flags a transmitter that never acknowledges a start.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, default 16: cycles allowed between `tx_start` and `tx_busy` rising, >= 2.
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending; held until acked.
- `req_data`  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- `req_ack`  out  NUM_REQ  one-cycle pulse: requester i's byte accepted.
- `tx_start`  out  1  one-cycle start pulse to transmitter.
- `tx_data_in`  out  8  byte to transmitter; stable from start until frame end.
- `tx_busy`  in  1  transmitter busy flag.
- `grant_id`  out  clog2(NUM_REQ)  index of current/last granted requester.
- `arb_busy`  out  1  high whenever state != IDLE.
- `err_timeout`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE. Encoding 2'b00..2'b11.
- IDLE: if `tx_busy`=0 and any `req_valid` set, select the first set bit scanning from `rr_ptr` upward with wrap-around; go START. If `tx_busy`=1, no grant.
- On IDLE->START edge, registered: `tx_data_in`<=selected byte, `grant_id`<=i, `req_ack[i]`<=1, `tx_start`<=1.
- START (1 cycle): `tx_start`, `req_ack` drop next edge; go WAIT_BUSY; clear watchdog.
- WAIT_BUSY: `tx_busy`=1 -> WAIT_DONE. Otherwise increment watchdog; at count BUSY_TIMEOUT-1 pulse `err_timeout`, go IDLE, `rr_ptr`<=i+1 (the byte is dropped; the requester was already acked).
- WAIT_DONE: wait for `tx_busy`=0 -> IDLE, `rr_ptr`<=(i+1) mod NUM_REQ. No timeout (frame length depends on baud).
- `rr_ptr` wraps NUM_REQ-1 -> 0. Requesters that deassert `req_valid` before ack are not granted. A requester holding valid after its ack is a new byte.
- Reset, any time, including mid-frame: state IDLE, `rr_ptr`=0, all outputs 0 (`tx_data_in`=8'h00, `grant_id`=0). Frames in the transmitter are not tracked across reset.

## Timing
- Request sampled in IDLE at edge n -> `tx_start` and `req_ack[i]` high during cycle n+1, exactly one cycle.
- Minimum grant-to-grant spacing: START + >=1 WAIT_BUSY + >=1 WAIT_DONE + IDLE = 4 cycles plus the frame time.
- `tx_busy` falling at edge m -> IDLE at m; next `tx_start` at m+1 at earliest.
- `tx_busy` already high in the START cycle: WAIT_BUSY sees it on the first cycle and exits immediately.
- All outputs registered. No combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`: state encodings and the `UART_DATA_W`=8 constant, common with `uart_tx_fsm`.
- Sub-module `uart_rr_pick`: combinational rotate-priority picker. Inputs: `req` vector and `ptr`. Outputs: `gnt_id` and `any`. Reusable for an RX-side arbiter.
- Top-level instantiation sits beside `top`: `tx_start`, `tx_data_in` and `tx_busy` connect port-to-port.

## Test plan
- Single requester: `req_valid`=4'b0001, data 8'hA5 -> one `tx_start` and `req_ack[0]` in the same cycle, `tx_data_in`=8'hA5 held until `tx_busy` falls; `grant_id`=0.
- All four requesters valid continuously, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0 across frames; each gets exactly one ack per frame.
- Pointer wrap: last grant 3, `req_valid`=4'b1001 -> next grant 0, then 3.
- Transmitter stuck (`tx_busy` tied 0) -> `err_timeout` pulse exactly BUSY_TIMEOUT cycles after the WAIT_BUSY entry, return to IDLE, next requester granted.
- `tx_busy`=1 in IDLE with requests pending -> no `tx_start` until `tx_busy` drops.
- `rstn` asserted mid-WAIT_DONE -> all outputs 0 asynchronously; after release, the first grant comes from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the arbiter state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StStart    = 2'b01,
    StWaitBusy = 2'b10,
    StWaitDone = 2'b11
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above ptr, with wrap.
module uart_rr_pick #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [IdW-1:0] gnt_id,
  output logic           any
);

  int unsigned idx;

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any && req[idx[IdW-1:0]]) begin
        any    = 1'b1;
        gnt_id = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers,
// with a watchdog on the start-to-busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned BUSY_TIMEOUT = 16,
  localparam int unsigned IdW          = $clog2(NUM_REQ),
  localparam int unsigned WdW          = $clog2(BUSY_TIMEOUT)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data_in,
  input  logic                           tx_busy,
  output logic [IdW-1:0]                 grant_id,
  output logic                           arb_busy,
  output logic                           err_timeout
);

  arb_state_e             state_q, state_d;
  logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WdW-1:0]         wdog_q, wdog_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic [IdW-1:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   start_q, start_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic [IdW-1:0]         pick_id;
  logic                   pick_any;
  logic [UART_DATA_W-1:0] pick_data;
  logic [IdW-1:0]         next_ptr;

  uart_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == IdW'(i)) begin
        pick_data = req_data[i*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  assign next_ptr = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    data_d   = data_q;
    grant_d  = grant_q;
    ack_d    = '0;
    start_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_busy && pick_any) begin
          state_d = StStart;
          data_d  = pick_data;
          grant_d = pick_id;
          start_d = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (pick_id == IdW'(i));
          end
        end
      end
      StStart: begin
        state_d = StWaitBusy;
        wdog_d  = '0;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (wdog_q == WdW'(BUSY_TIMEOUT - 1)) begin
          // Byte is dropped; the requester has already been acked.
          err_d    = 1'b1;
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ack     = ack_q;
  assign tx_start    = start_q;
  assign tx_data_in  = data_q;
  assign grant_id    = grant_q;
  assign arb_busy    = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a small transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data_in;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;

  logic        auto_busy;
  logic        man_busy;
  logic [2:0]  frame_cnt;

  int checks;
  int errors;
  int extra;
  bit ok;
  bit seen;

  always #5 clk = ~clk;

  // Transmitter model: busy for five cycles starting the edge after tx_start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
    end else if (tx_start) begin
      frame_cnt <= 3'd5;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1'b1;
    end
  end

  assign tx_busy = auto_busy ? (frame_cnt != 0) : man_busy;

  uart_tx_arbiter #(
    .NUM_REQ      (NumReq),
    .BUSY_TIMEOUT (Timeout)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_start    (tx_start),
    .tx_data_in  (tx_data_in),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0;
    rstn      = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_start) begin
        found = 1'b1;
        break;
      end
      if (req_ack != 0) extra++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    extra     = 0;
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    auto_busy = 1'b0;
    man_busy  = 1'b0;
    tick();
    tick();
    chk("reset_start", {31'd0, tx_start}, 32'd0);
    chk("reset_ack", {28'd0, req_ack}, 32'd0);
    chk("reset_data_grant", {22'd0, tx_data_in, grant_id}, 32'd0);
    chk("reset_busy_err", {30'd0, arb_busy, err_timeout}, 32'd0);
    rstn = 1'b1;
    tick();

    // Single requester
    req_data  = 32'h0000_00A5;
    req_valid = 4'b0001;
    tick();
    chk("single_start", {31'd0, tx_start}, 32'd1);
    chk("single_ack", {28'd0, req_ack}, 32'h1);
    chk("single_data", {24'd0, tx_data_in}, 32'hA5);
    chk("single_grant", {30'd0, grant_id}, 32'd0);
    chk("single_arb_busy", {31'd0, arb_busy}, 32'd1);
    req_valid = '0;
    tick();
    chk("single_start_drop", {31'd0, tx_start}, 32'd0);
    chk("single_ack_drop", {28'd0, req_ack}, 32'd0);
    man_busy = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("single_hold_data", {24'd0, tx_data_in}, 32'hA5);
    chk("single_wait_done_busy", {31'd0, arb_busy}, 32'd1);
    man_busy = 1'b0;
    tick();
    chk("single_idle", {31'd0, arb_busy}, 32'd0);
    chk("single_data_kept", {24'd0, tx_data_in}, 32'hA5);

    // Round robin with all four requesters continuously valid
    do_reset();
    auto_busy = 1'b1;
    req_data  = 32'h1312_1110;
    req_valid = 4'hF;
    extra     = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start(40, ok);
      chk("rr_start_seen", {31'd0, ok}, 32'd1);
      chk("rr_grant", {30'd0, grant_id}, k % 4);
      chk("rr_ack", {28'd0, req_ack}, 32'd1 << (k % 4));
      chk("rr_data", {24'd0, tx_data_in}, 32'h10 + (k % 4));
    end
    chk("rr_extra_acks", extra, 32'd0);

    // Pointer wrap
    do_reset();
    req_valid = 4'b1000;
    wait_start(40, ok);
    chk("wrap_first_seen", {31'd0, ok}, 32'd1);
    chk("wrap_first_grant", {30'd0, grant_id}, 32'd3);
    req_valid = 4'b1001;
    wait_start(40, ok);
    chk("wrap_second_grant", {30'd0, grant_id}, 32'd0);
    chk("wrap_second_data", {24'd0, tx_data_in}, 32'h10);
    wait_start(40, ok);
    chk("wrap_third_grant", {30'd0, grant_id}, 32'd3);

    // Stuck transmitter
    do_reset();
    auto_busy = 1'b0;
    man_busy  = 1'b0;
    req_valid = 4'b0011;
    tick();
    chk("to_start", {31'd0, tx_start}, 32'd1);
    chk("to_grant0", {30'd0, grant_id}, 32'd0);
    tick();
    repeat (Timeout - 1) tick();
    chk("to_err_early", {31'd0, err_timeout}, 32'd0);
    chk("to_still_busy", {31'd0, arb_busy}, 32'd1);
    tick();
    chk("to_err_pulse", {31'd0, err_timeout}, 32'd1);
    chk("to_idle", {31'd0, arb_busy}, 32'd0);
    tick();
    chk("to_err_clear", {31'd0, err_timeout}, 32'd0);
    chk("to_next_start", {31'd0, tx_start}, 32'd1);
    chk("to_next_grant", {30'd0, grant_id}, 32'd1);

    // Transmitter busy while idle blocks grants
    do_reset();
    man_busy  = 1'b1;
    req_valid = 4'b0100;
    seen      = 1'b0;
    repeat (6) begin
      tick();
      if (tx_start) seen = 1'b1;
    end
    chk("busy_idle_no_start", {31'd0, seen}, 32'd0);
    chk("busy_idle_arb", {31'd0, arb_busy}, 32'd0);
    man_busy = 1'b0;
    tick();
    chk("busy_release_start", {31'd0, tx_start}, 32'd1);
    chk("busy_release_grant", {30'd0, grant_id}, 32'd2);
    chk("busy_release_ack", {28'd0, req_ack}, 32'h4);
    req_valid = '0;
    tick();
    man_busy = 1'b1;
    tick();
    tick();
    chk("mid_frame_busy", {31'd0, arb_busy}, 32'd1);

    // Asynchronous reset in WAIT_DONE
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_data", {24'd0, tx_data_in}, 32'd0);
    chk("arst_grant", {30'd0, grant_id}, 32'd0);
    chk("arst_flags", {29'd0, arb_busy, tx_start, err_timeout}, 32'd0);
    chk("arst_ack", {28'd0, req_ack}, 32'd0);
    tick();
    rstn      = 1'b1;
    man_busy  = 1'b0;
    req_valid = 4'b1111;
    tick();
    chk("post_rst_start", {31'd0, tx_start}, 32'd1);
    chk("post_rst_grant", {30'd0, grant_id}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
